// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
package cpu_pkg;

    localparam int unsigned DefaultAw = 32;
    localparam int unsigned DefaultDw = 32;

    // Value delivered to a stage whose access timed out.
    localparam logic [31:0] TimeoutFill = 32'h0;

    typedef enum logic [1:0] {
        StIdle,
        StBusyDm,
        StBusyIf
    } arb_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for one outstanding memory access; flags the cycle that hits Limit.
module mem_wait_timer #(
    parameter int unsigned Limit = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(Limit + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(Limit);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Asserted on the waiting cycle whose increment brings the count to Limit.
    assign expire_o = inc_i && (cnt_q >= (CntMax - CntW'(1)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory port between the IF and MEM stages and stalls the pipeline meanwhile.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned AW      = DefaultAw,
    parameter int unsigned DW      = DefaultDw,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [DW-1:0] if_data_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    output logic [DW-1:0] dm_rdata_o,
    output logic          stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          err_o
);

    arb_state_e    state_q, state_d;
    logic          if_done_q, if_done_d;
    logic          dm_done_q, dm_done_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_data_q, if_data_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          err_q, err_d;
    logic          advance, issue, wait_inc, wait_expire;

    assign stall_o  = (if_req_i & ~if_done_q) | (dm_req_i & ~dm_done_q);
    assign advance  = ~stall_o;
    assign wait_inc = (state_q != StIdle) & ~mem_ack_i;

    mem_wait_timer #(
        .Limit (TIMEOUT)
    ) u_wait_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (issue),
        .inc_i    (wait_inc),
        .expire_o (wait_expire)
    );

    always_comb begin
        state_d     = state_q;
        if_done_d   = if_done_q;
        dm_done_d   = dm_done_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        dm_rdata_d  = dm_rdata_q;
        err_d       = err_q;
        issue       = 1'b0;
        unique case (state_q)
            StIdle: begin
                // DM first: it belongs to the older instruction.
                if (dm_req_i && !dm_done_q && !advance) begin
                    issue       = 1'b1;
                    state_d     = StBusyDm;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                end else if (if_req_i && !if_done_q && !advance) begin
                    issue      = 1'b1;
                    state_d    = StBusyIf;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr_i;
                end
            end
            StBusyDm: begin
                if (mem_ack_i) begin
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end
                    dm_done_d = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end else if (wait_expire) begin
                    dm_rdata_d = DW'(TimeoutFill);
                    err_d      = 1'b1;
                    dm_done_d  = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = StIdle;
                end
            end
            StBusyIf: begin
                if (mem_ack_i) begin
                    if_data_d = mem_rdata_i;
                    if_done_d = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end else if (wait_expire) begin
                    if_data_d = DW'(TimeoutFill);
                    err_d     = 1'b1;
                    if_done_d = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A completion that lands on an advance belongs to a step nobody is waiting on any more.
        if (advance) begin
            if_done_d = 1'b0;
            dm_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_data_o   = if_data_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level expectation queue, latency-programmable memory.
module tb_mem_port_arbiter;

    localparam int unsigned Timeout = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [31:0] if_data, dm_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        stall, mem_req, mem_we, err;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (Timeout)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_data_o   (if_data),
        .dm_req_i    (dm_req),
        .dm_we_i     (dm_we),
        .dm_addr_i   (dm_addr),
        .dm_wdata_i  (dm_wdata),
        .dm_rdata_o  (dm_rdata),
        .stall_o     (stall),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .err_o       (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hA5C30F1E;
    endfunction

    // Memory responder: acks in the N-th cycle mem_req is seen high, N taken from lat_q.
    logic [31:0] mem_arr [logic [31:0]];
    int          lat_q[$];
    int          cur_lat = 0;
    int          waited = 0;
    bit          busy = 1'b0;

    always @(negedge clk) begin
        if (!mem_req) begin
            busy    = 1'b0;
            mem_ack = 1'b0;
        end else begin
            if (!busy) begin
                busy    = 1'b1;
                waited  = 0;
                cur_lat = 1000;
                if (lat_q.size() != 0) cur_lat = lat_q.pop_front();
            end
            waited++;
            mem_ack = (waited == cur_lat);
            mem_rdata = $urandom;
            if (mem_ack) begin
                if (!mem_arr.exists(mem_addr)) mem_arr[mem_addr] = init_word(mem_addr);
                if (mem_we) mem_arr[mem_addr] = mem_wdata;
                else mem_rdata = mem_arr[mem_addr];
            end
        end
    end

    // Reference model: what each cycle of a pipeline step must look like.
    typedef struct {
        logic        stall;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ifd;
        logic [31:0] dmd;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur_e;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] exp_if = '0, exp_dm = '0;
    logic        exp_err = 1'b0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        mem_arr[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic push_rec(input logic s, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e.stall = s; e.req = r; e.we = w; e.addr = a; e.wdata = wd;
        e.ifd = exp_if; e.dmd = exp_dm; e.err = exp_err;
        exp_q.push_back(e);
    endtask

    // One access = an issue cycle plus min(latency, Timeout) cycles with the request up.
    task automatic gen_access(input bit is_dm, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input int lat);
        int n;
        push_rec(1'b1, 1'b0, 1'b0, '0, '0);
        lat_q.push_back(lat);
        n = (lat < int'(Timeout)) ? lat : int'(Timeout);
        for (int k = 0; k < n; k++) push_rec(1'b1, 1'b1, we, a, wd);
        if (lat <= int'(Timeout)) begin
            if (is_dm) begin
                if (we) ref_mem[a] = wd;
                else exp_dm = ref_rd(a);
            end else begin
                exp_if = ref_rd(a);
            end
        end else begin
            exp_err = 1'b1;
            if (is_dm) exp_dm = 32'h0;
            else exp_if = 32'h0;
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur_e = exp_q.pop_front();
            check("stall_o", stall, cur_e.stall);
            check("mem_req_o", mem_req, cur_e.req);
            if (cur_e.req) begin
                check("mem_we_o", mem_we, cur_e.we);
                check("mem_addr_o", mem_addr, cur_e.addr);
                if (cur_e.we) check("mem_wdata_o", mem_wdata, cur_e.wdata);
            end
            check("if_data_o", if_data, cur_e.ifd);
            check("dm_rdata_o", dm_rdata, cur_e.dmd);
            check("err_o", err, cur_e.err);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the step's advance cycle.
    task automatic run_step(input bit ir, input bit dr, input bit we, input logic [31:0] ia,
                            input logic [31:0] da, input logic [31:0] wd,
                            input int ldm, input int lif);
        int n;
        if_req = ir; dm_req = dr; dm_we = we;
        if_addr = ia; dm_addr = da; dm_wdata = wd;
        if (dr) gen_access(1'b1, we, da, wd, ldm);
        if (ir) gen_access(1'b0, 1'b0, ia, '0, lif);
        push_rec(1'b0, 1'b0, 1'b0, '0, '0);
        n = exp_q.size();
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int rand_lat();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(5, 10));
        return int'($urandom_range(1, 4));
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        #1;
        check("reset stall_o", stall, 32'h0);
        check("reset mem_req_o", mem_req, 32'h0);
        check("reset if_data_o", if_data, 32'h0);
        check("reset dm_rdata_o", dm_rdata, 32'h0);
        check("reset err_o", err, 32'h0);
        @(posedge clk);
        #1;

        preload(32'h0, 32'h2002000A);
        run_step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 1);
        check("fetch literal", if_data, 32'h2002000A);

        preload(32'h40, 32'h12345678);
        preload(32'h4, 32'h00000013);
        run_step(1'b1, 1'b1, 1'b0, 32'h4, 32'h40, 32'h0, 1, 1);
        check("load literal", dm_rdata, 32'h12345678);
        check("fetch after load", if_data, 32'h00000013);

        run_step(1'b1, 1'b1, 1'b1, 32'h8, 32'h44, 32'hCAFEF00D, 3, 1);
        check("store keeps dm_rdata", dm_rdata, 32'h12345678);
        check("store reached memory", mem_arr[32'h44], 32'hCAFEF00D);
        run_step(1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 32'h0, 2, 0);
        check("load back store", dm_rdata, 32'hCAFEF00D);

        preload(32'hC, 32'h0BADC0DE);
        run_step(1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 32'h0, 0, 1000);
        check("timeout err_o", err, 32'h1);
        check("timeout fill", if_data, 32'h0);
        run_step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 1);
        check("err_o sticky", err, 32'h1);
        check("fetch after timeout", if_data, 32'h2002000A);

        for (int i = 0; i < 1000; i++) begin
            run_step(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)),
                     32'h100 + ($urandom_range(0, 63) << 2),
                     32'h100 + ($urandom_range(0, 63) << 2), $urandom,
                     rand_lat(), rand_lat());
        end

        // Reset landing in BUSY_DM on the same cycle as the ack.
        run_step(1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0, 1, 0);
        check("pre-reset dm_rdata", dm_rdata, 32'h12345678);
        if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        lat_q.push_back(1);
        @(posedge clk);
        #1;
        check("busy before reset", mem_req, 32'h1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check("reset mid mem_req_o", mem_req, 32'h0);
        check("reset mid dm_rdata_o", dm_rdata, 32'h0);
        check("reset mid err_o", err, 32'h0);
        check("reset mid if_data_o", if_data, 32'h0);
        check("reset mid stall_o", stall, 32'h1);
        dm_req = 1'b0;
        lat_q.delete();
        exp_if = '0; exp_dm = '0; exp_err = 1'b0;
        @(posedge clk);
        #1 rst_i = 1'b0;
        #1 check("post reset stall_o", stall, 32'h0);
        @(posedge clk);
        #1;
        run_step(1'b1, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0, 1, 2);
        check("after reset load", dm_rdata, 32'h12345678);
        check("after reset fetch", if_data, 32'h2002000A);

        if_req = 1'b0; dm_req = 1'b0;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
